// File: rtl/ring_pkg.sv
// ring_pkg -- definitions shared by the LED ring sequencer files.
//   state_t            : sequencer FSM states (IDLE, RUN, HOLD)
//   RING_RESET_PATTERN : ring value after reset or start (bit0 lit)
//   RING_DIV_W         : default prescaler width in bits
package ring_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned RING_RESET_PATTERN = 1;
  localparam int          RING_DIV_W         = 22;

endpackage

// File: rtl/ring_prescaler.sv
// ring_prescaler -- step-rate divider for the LED ring sequencer.
// Counts enabled cycles. TICK is high in the cycle where the count equals DIV,
// and the count returns to 0 at that edge, so one step lasts DIV+1 cycles.
// While EN is low the count holds, which lets a pause resume mid-period.
// Ports:
//   CLK    : clock, rising edge
//   RESETN : asynchronous active-low reset
//   EN     : count enable
//   CLR    : synchronous clear (wins over EN)
//   DIV    : terminal count (step period minus 1)
//   TICK   : combinational terminal-count pulse, only while EN is high
module ring_prescaler
  import ring_pkg::*;
#(
  parameter int DIV_W = RING_DIV_W
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             EN,
  input  logic             CLR,
  input  logic [DIV_W-1:0] DIV,
  output logic             TICK
);

  logic [DIV_W-1:0] count;

  assign TICK = EN && (count == DIV);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count <= '0;
    end else if (CLR) begin
      count <= '0;
    end else if (EN) begin
      if (TICK) count <= '0;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_ring_sequencer.sv
// led_ring_sequencer -- one-hot LED ring stepper with rotate and bounce modes.
// Optional feature macro: RING_BOUNCE_EN. When defined, MODE=1 selects bounce
// (reverse at either end). When undefined, MODE is ignored and the ring always
// rotates; the direction-reversal logic is not built.
// Ports:
//   CLK    : clock, rising edge
//   RESETN : asynchronous active-low reset
//   START  : start request, honoured only in IDLE (and only with STOP low)
//   STOP   : stop request in RUN/HOLD; beats PAUSE and a pending step
//   PAUSE  : level hold; freezes ring and prescaler while high
//   DIR    : 0 = toward MSB, 1 = toward LSB; latched on start
//   MODE   : 0 = rotate, 1 = bounce; latched on start
//   DIV    : step period minus 1; latched on start
//   O      : one-hot ring pattern
//   BUSY   : high in RUN or HOLD
//   TICK   : one-cycle pulse on each step
//   WRAP   : one-cycle pulse on a step that wraps or reverses
module led_ring_sequencer
  import ring_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = RING_DIV_W
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic             DIR,
  input  logic             MODE,
  input  logic [DIV_W-1:0] DIV,
  output logic [WIDTH-1:0] O,
  output logic             BUSY,
  output logic             TICK,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] RESET_PAT = WIDTH'(RING_RESET_PATTERN);

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_q;
  logic             dir_q;
  logic             start_go;
  logic             run_en;
  logic             clr;
  logic             tick;
  logic             at_end;
  logic [WIDTH-1:0] o_nx;

  assign start_go = (state == IDLE) && START && !STOP;
  // STOP and PAUSE both gate the count enable, so neither cycle can step.
  assign run_en   = (state == RUN) && !STOP && !PAUSE;
  // Holding the count clear throughout IDLE also covers the RUN entry edge.
  assign clr      = (state == IDLE) || STOP;

  ring_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .CLK    (CLK),
    .RESETN (RESETN),
    .EN     (run_en),
    .CLR    (clr),
    .DIV    (div_q),
    .TICK   (tick)
  );

  assign TICK = tick;
  assign WRAP = tick && at_end;
  assign BUSY = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (START && !STOP) state_nx = RUN;
      RUN: begin
        if (STOP)       state_nx = IDLE;
        else if (PAUSE) state_nx = HOLD;
      end
      HOLD: begin
        if (STOP)        state_nx = IDLE;
        else if (!PAUSE) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nx;
  end

`ifdef RING_BOUNCE_EN
  logic mode_q;
  logic bdir;
  logic bdir_nx;
  logic step_dir;

  // Bounce follows its own reversing flag; rotate keeps the latched direction.
  assign step_dir = mode_q ? bdir : dir_q;

  always_comb begin
    o_nx    = O;
    at_end  = 1'b0;
    bdir_nx = bdir;
    if (!step_dir) begin
      at_end = O[WIDTH-1];
      if (mode_q && at_end) begin
        o_nx    = O >> 1;
        bdir_nx = 1'b1;
      end else begin
        o_nx = {O[WIDTH-2:0], O[WIDTH-1]};
      end
    end else begin
      at_end = O[0];
      if (mode_q && at_end) begin
        o_nx    = O << 1;
        bdir_nx = 1'b0;
      end else begin
        o_nx = {O[0], O[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      mode_q <= 1'b0;
      bdir   <= 1'b0;
    end else if (start_go) begin
      mode_q <= MODE;
      bdir   <= DIR;
    end else if (tick) begin
      bdir   <= bdir_nx;
    end
  end
`else
  logic mode_unused;
  assign mode_unused = MODE;

  always_comb begin
    o_nx   = O;
    at_end = 1'b0;
    if (!dir_q) begin
      at_end = O[WIDTH-1];
      o_nx   = {O[WIDTH-2:0], O[WIDTH-1]};
    end else begin
      at_end = O[0];
      o_nx   = {O[0], O[WIDTH-1:1]};
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      O     <= RESET_PAT;
      div_q <= '0;
      dir_q <= 1'b0;
    end else if (start_go) begin
      O     <= RESET_PAT;
      div_q <= DIV;
      dir_q <= DIR;
    end else if (tick) begin
      O     <= o_nx;
    end
  end

endmodule

// File: tb/tb_led_ring_sequencer.sv
// tb_led_ring_sequencer -- self-checking bench for led_ring_sequencer.
// The reference model tracks the lit position as an integer index plus a
// step counter and a run/hold/idle status, and predicts O, BUSY, TICK and WRAP
// for every cycle. Directed sequences add literal expectations.
module tb_led_ring_sequencer;

  localparam int W  = 8;
  localparam int DW = 22;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic          START, STOP, PAUSE, DIR, MODE;
  logic [DW-1:0] DIV;
  logic [W-1:0]  O;
  logic          BUSY, TICK, WRAP;

  led_ring_sequencer #(.WIDTH(W), .DIV_W(DW)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .START  (START),
    .STOP   (STOP),
    .PAUSE  (PAUSE),
    .DIR    (DIR),
    .MODE   (MODE),
    .DIV    (DIV),
    .O      (O),
    .BUSY   (BUSY),
    .TICK   (TICK),
    .WRAP   (WRAP)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // model: 0 = idle, 1 = running, 2 = held
  int m_state, m_pos, m_cnt, m_div, m_dir, m_bounce;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_cnt = 0; m_div = 0; m_dir = 0; m_bounce = 0;
  endtask

  function automatic void advance(input int pos, input int dir, input int bounce,
                                  output int npos, output int ndir, output bit w);
    ndir = dir;
    w    = 1'b0;
    if (dir == 0) begin
      if (pos == W-1) begin
        w = 1'b1;
        if (bounce != 0) begin npos = W-2; ndir = 1; end
        else npos = 0;
      end else npos = pos + 1;
    end else begin
      if (pos == 0) begin
        w = 1'b1;
        if (bounce != 0) begin npos = 1; ndir = 0; end
        else npos = W-1;
      end else npos = pos - 1;
    end
  endfunction

  // One clock: drive inputs after the edge, compare at the falling edge,
  // then move the model across the next rising edge.
  task automatic step(input bit st, input bit sp, input bit pa, input bit d,
                      input bit m, input int dv);
    bit et, ew;
    int npos, ndir;
    @(posedge CLK);
    #1;
    START = st; STOP = sp; PAUSE = pa; DIR = d; MODE = m; DIV = DW'(dv);
    @(negedge CLK);
    et = (m_state == 1) && !sp && !pa && (m_cnt == m_div);
    advance(m_pos, m_dir, m_bounce, npos, ndir, ew);
    ew = ew && et;
    check("O",    32'(O),    32'(1) << m_pos);
    check("BUSY", 32'(BUSY), 32'(m_state != 0));
    check("TICK", 32'(TICK), 32'(et));
    check("WRAP", 32'(WRAP), 32'(ew));
    case (m_state)
      0: if (st && !sp) begin
        m_state = 1; m_pos = 0; m_cnt = 0; m_div = dv; m_dir = d;
`ifdef RING_BOUNCE_EN
        m_bounce = m;
`else
        m_bounce = 0;
`endif
      end
      1: begin
        if (sp) begin m_state = 0; m_cnt = 0; end
        else if (pa) m_state = 2;
        else if (et) begin m_cnt = 0; m_pos = npos; m_dir = ndir; end
        else m_cnt++;
      end
      default: begin
        if (sp) begin m_state = 0; m_cnt = 0; end
        else if (!pa) m_state = 1;
      end
    endcase
  endtask

  // Reset asserted between edges; outputs must change without a clock edge.
  task automatic async_reset();
    #2;
    RESETN = 1'b0;
    #1;
    model_reset();
    check("rst_O",    32'(O),    32'h01);
    check("rst_BUSY", 32'(BUSY), 32'h0);
    check("rst_TICK", 32'(TICK), 32'h0);
    check("rst_WRAP", 32'(WRAP), 32'h0);
    START = 0; STOP = 0; PAUSE = 0;
    @(posedge CLK);
    #2;
    RESETN = 1'b1;
  endtask

  logic [W-1:0] seq_o [16];
  logic [15:0]  seq_t, seq_w;

  initial begin
    RESETN = 1'b0;
    START = 0; STOP = 0; PAUSE = 0; DIR = 0; MODE = 0; DIV = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("init_O",    32'(O),    32'h01);
    check("init_BUSY", 32'(BUSY), 32'h0);
    #1;
    RESETN = 1'b1;

    // DIV=3 rotate left: tick every 4 cycles, wrap on 80 -> 01
    step(1, 0, 0, 0, 0, 3);
    seq_t = '0; seq_w = '0;
    for (int k = 0; k < 33; k++) begin
      step(0, 0, 0, 0, 0, 0);
      if (k < 16) seq_t[k] = TICK;
      if (k == 28) check("div3_O80", 32'(O), 32'h80);
      if (k == 31) check("div3_wrap", 32'(WRAP), 32'h1);
      if (k == 32) check("div3_O01", 32'(O), 32'h01);
    end
    check("div3_ticks", 32'(seq_t), 32'h8888);

    // DIV=0 rotate right: 01, 80, 40 with wrap on the first step
    async_reset();
    step(1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 0, 0);
      seq_o[k] = O;
      seq_w[k] = WRAP;
    end
    check("dir1_O", {8'h0, seq_o[0], seq_o[1], seq_o[2]}, 32'h00018040);
    check("dir1_wrap", 32'(seq_w[2:0]), 32'h1);

`ifdef RING_BOUNCE_EN
    // bounce, DIV=0, 16 cycles
    async_reset();
    step(1, 0, 0, 0, 1, 0);
    seq_w = '0;
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 0, 1, 0);
      seq_o[k] = O;
      seq_w[k] = WRAP;
    end
    check("bnc_O7",  32'(seq_o[7]),  32'h80);
    check("bnc_O8",  32'(seq_o[8]),  32'h40);
    check("bnc_O14", 32'(seq_o[14]), 32'h01);
    check("bnc_O15", 32'(seq_o[15]), 32'h02);
    check("bnc_wrap", 32'(seq_w), 32'h4080);
`endif

    // DIV=9, pause for 5 cycles at count 6; tick 4 cycles after the drop
    async_reset();
    step(1, 0, 0, 0, 0, 9);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0, 9);
    seq_t = '0;
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 0, 9);
      seq_t[k] = TICK;
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0, 9);
      seq_t[k+5] = TICK;
    end
    check("pause_ticks", 32'(seq_t), 32'h0200);

    // STOP on a tick cycle: no step, O kept, idle next; restart gives 01
    async_reset();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("stop_tick", 32'(TICK), 32'h0);
    check("stop_O", 32'(O), 32'h04);
    step(0, 0, 0, 0, 0, 0);
    check("stop_busy", 32'(BUSY), 32'h0);
    check("stop_Okeep", 32'(O), 32'h04);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("restart_O", 32'(O), 32'h01);

    // reset mid-run at O=10, then START+STOP together stays idle
    async_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0);
    check("mid_O10", 32'(O), 32'h10);
    async_reset();
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("ss_busy", 32'(BUSY), 32'h0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_ring_sequencer.md
LED_RING_SEQUENCER -- requirements
Module: led_ring_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: ring length in bits, minimum 2.
REQ-002 Parameter DIV_W, default 22: prescaler width in bits.
REQ-003 Port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port RESETN, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port START, input, 1: start request, sampled only in IDLE.
REQ-006 Port STOP, input, 1: stop request, sampled in RUN and HOLD.
REQ-007 Port PAUSE, input, 1: level-sensitive hold.
REQ-008 Port DIR, input, 1: direction, 0 = toward MSB, 1 = toward LSB; latched on START.
REQ-009 Port MODE, input, 1: pattern, 0 = rotate, 1 = bounce; latched on START.
REQ-010 Port DIV, input, DIV_W: step period minus 1; latched on START.
REQ-011 Port O, output, WIDTH: one-hot ring pattern.
REQ-012 Port BUSY, output, 1: high in RUN or HOLD.
REQ-013 Port TICK, output, 1: one-cycle pulse on each step.
REQ-014 Port WRAP, output, 1: one-cycle pulse on each wrap or reversal.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and HOLD; the reset state SHALL be IDLE.
REQ-016 IDLE with START=1 and STOP=0 SHALL, on the next edge:
  - enter RUN;
  - latch DIR, MODE and DIV;
  - set O=1 (bit0);
  - clear the prescaler.
REQ-017 In RUN, the prescaler SHALL increment every cycle; when it equals the latched DIV, TICK SHALL be 1 in that cycle and the prescaler SHALL return to 0.
REQ-018 The step period SHALL be DIV+1 cycles; DIV=0 SHALL give TICK every RUN cycle.
REQ-019 The first TICK SHALL occur DIV+1 cycles after the RUN entry edge.
REQ-020 On TICK, O SHALL advance one position at the same edge.
REQ-021 Rotate mode:
  - direction 0: O rotates left, and bit WIDTH-1 wraps to bit0;
  - direction 1: O rotates right, and bit0 wraps to bit WIDTH-1;
  - WRAP SHALL equal TICK on wrap cycles.
REQ-022 Bounce mode: O SHALL shift without wrap; when O is at the end bit in the current direction, the TICK SHALL reverse an internal direction flag and move O one position back; WRAP SHALL pulse on that TICK.
REQ-023 RUN with PAUSE=1 SHALL enter HOLD; HOLD SHALL freeze the prescaler and O, and TICK and WRAP SHALL stay 0.
REQ-024 HOLD with PAUSE=0 SHALL return to RUN, resuming the prescaler count where it stopped.
REQ-025 STOP=1 in RUN or HOLD SHALL enter IDLE on the next edge:
  - O keeps its last value;
  - the prescaler clears;
  - no TICK is issued in that cycle.
REQ-026 STOP SHALL take priority over PAUSE and over TICK in the same cycle.
REQ-027 START SHALL be ignored outside IDLE.
REQ-028 START and STOP both high in IDLE SHALL leave the block in IDLE.
REQ-029 O SHALL be one-hot in every cycle after reset.

Reset
REQ-030 RESETN=0 SHALL immediately force:
  - state IDLE;
  - O=1;
  - prescaler 0;
  - latched DIR=0, MODE=0, DIV=0;
  - internal direction 0;
  - BUSY, TICK and WRAP = 0.
REQ-031 Reset asserted mid-RUN SHALL abort without completing the pending step; the release edge SHALL NOT generate TICK.

Configuration
REQ-032 With RING_BOUNCE_EN defined, MODE SHALL behave per REQ-022.
REQ-033 Without RING_BOUNCE_EN, MODE SHALL be ignored, rotate mode SHALL always apply, and the internal direction-reversal logic SHALL not be built.

Structure
REQ-034 The shared package ring_pkg SHALL hold:
  - the state enum (IDLE, RUN, HOLD);
  - the constants RING_RESET_PATTERN (bit0) and the default DIV_W.
REQ-035 The prescaler SHALL be a sub-module ring_prescaler with ports CLK, RESETN, EN, CLR, DIV and TICK.
REQ-036 The FSM and ring register SHALL live in the top module.

Verification
REQ-037 DIV=3, DIR=0, MODE=0, START for 1 cycle: TICK every 4 cycles; O = 01, 02, 04, ..., 80, 01; WRAP on the 80->01 step.
REQ-038 DIV=0, DIR=1, MODE=0: O = 01, 80, 40 on consecutive cycles; WRAP on the first step.
REQ-039 RING_BOUNCE_EN defined, DIV=0, MODE=1, DIR=0, 16 cycles:
  - O = 01..80, then 40..01, then 02;
  - WRAP at the 80->40 and 01->02 steps.
REQ-040 DIV=9, PAUSE high for 5 cycles starting at prescaler count 6:
  - no TICK during the pause;
  - the next TICK comes 4 cycles after PAUSE drops.
REQ-041 STOP on the same cycle as a TICK: the next state is IDLE, O unchanged, BUSY=0; a new START resets O to 01.
REQ-042 RESETN pulsed low mid-RUN with O=10: O=01 and BUSY=0 immediately; START and STOP high together in IDLE keep BUSY=0.
